// File: rtl/conv_layer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// conv_ctrl_pkg
// Shared definitions for the convolution layer controller:
//   - default parameter values for the controller and its stream generators
//   - FSM state encodings (also visible on the controller's state output)
//   - a helper that turns a byte count into a bus-word count
// ---------------------------------------------------------------------------
package conv_ctrl_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DIM_W     = 8;
  localparam int DEF_KW_W      = 4;
  localparam int DEF_BUS_BYTES = 4;

  // Word counters are always 32 bits so the largest product of the
  // dimension fields cannot overflow.
  localparam int CNT_W = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CFG   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_CAL   = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Rounds a byte count up to whole bus words. The bus width is a power of
  // two, so the division is a shift plus a carry-in from any leftover bytes.
  function automatic logic [CNT_W-1:0] ceilWords(input logic [CNT_W-1:0] nBytes,
                                                 input int unsigned     shift);
    logic [CNT_W-1:0] mask;
    mask = ~({CNT_W{1'b1}} << shift);
    return (nBytes >> shift) + CNT_W'(|(nBytes & mask));
  endfunction

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_layer_ctrl_if
// Memory-side handshake bundle of the convolution layer controller.
//   ifm_rd_*  : input-feature-map read requests  (valid/addr out, ready in)
//   wgt_rd_*  : weight read requests             (valid/addr out, ready in)
//   ofm_wr_*  : output-feature-map write requests (valid/addr out, ready in)
// master : the controller side (drives valid/addr)
// slave  : the memory side (drives ready)
// ---------------------------------------------------------------------------
interface conv_layer_ctrl_if
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              ifm_rd_valid;
  logic [ADDR_W-1:0] ifm_rd_addr;
  logic              ifm_rd_ready;

  logic              wgt_rd_valid;
  logic [ADDR_W-1:0] wgt_rd_addr;
  logic              wgt_rd_ready;

  logic              ofm_wr_valid;
  logic [ADDR_W-1:0] ofm_wr_addr;
  logic              ofm_wr_ready;

  modport master (
    output ifm_rd_valid, ifm_rd_addr, input ifm_rd_ready,
    output wgt_rd_valid, wgt_rd_addr, input wgt_rd_ready,
    output ofm_wr_valid, ofm_wr_addr, input ofm_wr_ready
  );

  modport slave (
    input ifm_rd_valid, ifm_rd_addr, output ifm_rd_ready,
    input wgt_rd_valid, wgt_rd_addr, output wgt_rd_ready,
    input ofm_wr_valid, ofm_wr_addr, output ofm_wr_ready
  );

endinterface

// File: rtl/conv_layer_ctrl_mem_stream_gen.sv
// ---------------------------------------------------------------------------
// mem_stream_gen
// Issues a run of bus-word requests: word k goes to base + k*BUS_BYTES.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : returns the word counter to zero
//   i_go         : channel is allowed to issue
//   i_base       : byte base address of the run
//   i_count      : number of words in the run
//   i_ready      : consumer accepts the current word
//   o_valid      : a word is being offered
//   o_addr       : byte address of the offered word (held until accepted)
//   o_finished   : every word of the run has been accepted
// ---------------------------------------------------------------------------
module mem_stream_gen
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BUS_BYTES = DEF_BUS_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_go,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_finished
);

  localparam int SHIFT = $clog2(BUS_BYTES);

  logic [CNT_W-1:0] r_beats;

  // The address is derived from the accepted-word count, so it cannot move
  // while a word is waiting for ready.
  assign o_finished = (r_beats >= i_count);
  assign o_valid    = i_go && !o_finished;
  assign o_addr     = i_base + (ADDR_W'(r_beats) << SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_beats <= '0;
    else if (i_clear)            r_beats <= '0;
    else if (o_valid && i_ready) r_beats <= r_beats + CNT_W'(1);
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// ---------------------------------------------------------------------------
// conv_layer_ctrl
// Sequences one convolution layer: latch config, size the transfers, read
// IFM and weights in parallel, hand off to the compute engine, write the OFM.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_start, i_abort                : launch / cancel a layer
//   i_ifm_base/i_wgt_base/i_ofm_base: byte base addresses
//   i_kernel_w, i_ifm_w, i_ifm_c,
//   i_ofm_w, i_ofm_c, i_stride      : layer geometry
//   mem                             : IFM/weight read and OFM write handshakes
//   o_cal_start, i_done_compute     : compute engine launch / completion
//   o_busy, o_done, o_cfg_err       : status (done is a pulse, cfg_err sticky)
//   o_state                         : current FSM state encoding
//   o_*_out                         : latched geometry
// ---------------------------------------------------------------------------
module conv_layer_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DIM_W     = DEF_DIM_W,
  parameter int KW_W      = DEF_KW_W,
  parameter int BUS_BYTES = DEF_BUS_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_ifm_base,
  input  logic [ADDR_W-1:0] i_wgt_base,
  input  logic [ADDR_W-1:0] i_ofm_base,
  input  logic [KW_W-1:0]   i_kernel_w,
  input  logic [DIM_W-1:0]  i_ifm_w,
  input  logic [DIM_W-1:0]  i_ifm_c,
  input  logic [DIM_W-1:0]  i_ofm_w,
  input  logic [DIM_W-1:0]  i_ofm_c,
  input  logic [1:0]        i_stride,
  conv_layer_ctrl_if.master mem,
  output logic              o_cal_start,
  input  logic              i_done_compute,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err,
  output logic [2:0]        o_state,
  output logic [KW_W-1:0]   o_kernel_w_out,
  output logic [DIM_W-1:0]  o_ifm_w_out,
  output logic [DIM_W-1:0]  o_ifm_c_out,
  output logic [DIM_W-1:0]  o_ofm_w_out,
  output logic [DIM_W-1:0]  o_ofm_c_out,
  output logic [1:0]        o_stride_out
);

  localparam int SHIFT = $clog2(BUS_BYTES);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [KW_W-1:0]   r_kernel_w;
  logic [DIM_W-1:0]  r_ifm_w, r_ifm_c, r_ofm_w, r_ofm_c;
  logic [1:0]        r_stride;
  logic [ADDR_W-1:0] r_ifm_base, r_wgt_base, r_ofm_base;
  logic [CNT_W-1:0]  r_ifm_words, r_wgt_words, r_ofm_words;
  logic [CNT_W-1:0]  w_ifm_words, w_wgt_words, w_ofm_words;
  logic              r_cfg_err, r_cal_start;
  logic              w_cfg_bad, w_clear;
  logic              w_ifm_fin, w_wgt_fin, w_ofm_fin;

  assign w_ifm_words = ceilWords(CNT_W'(r_ifm_w) * CNT_W'(r_ifm_w) * CNT_W'(r_ifm_c), SHIFT);
  assign w_wgt_words = ceilWords(CNT_W'(r_kernel_w) * CNT_W'(r_kernel_w) *
                                 CNT_W'(r_ifm_c) * CNT_W'(r_ofm_c), SHIFT);
  assign w_ofm_words = ceilWords(CNT_W'(r_ofm_w) * CNT_W'(r_ofm_w) * CNT_W'(r_ofm_c), SHIFT);

  assign w_cfg_bad = (r_kernel_w == '0) || (r_ifm_w == '0) || (r_ifm_c == '0) ||
                     (r_ofm_w == '0) || (r_ofm_c == '0) || (r_stride == '0);

  // Counters restart whenever the controller is idle, and on abort so a
  // cancelled layer leaves nothing behind for the next one.
  assign w_clear = (r_state == ST_IDLE) || i_abort;

  // Abort is applied last so it overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_CFG;
      ST_CFG:   w_next = w_cfg_bad ? ST_IDLE : ST_LOAD;
      ST_LOAD:  if (w_ifm_fin && w_wgt_fin) w_next = ST_CAL;
      ST_CAL:   if (i_done_compute) w_next = ST_STORE;
      ST_STORE: if (w_ofm_fin) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (i_abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Geometry and bases are captured only when a layer is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernel_w <= '0;
      r_ifm_w    <= '0;
      r_ifm_c    <= '0;
      r_ofm_w    <= '0;
      r_ofm_c    <= '0;
      r_stride   <= '0;
      r_ifm_base <= '0;
      r_wgt_base <= '0;
      r_ofm_base <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_kernel_w <= i_kernel_w;
      r_ifm_w    <= i_ifm_w;
      r_ifm_c    <= i_ifm_c;
      r_ofm_w    <= i_ofm_w;
      r_ofm_c    <= i_ofm_c;
      r_stride   <= i_stride;
      r_ifm_base <= i_ifm_base;
      r_wgt_base <= i_wgt_base;
      r_ofm_base <= i_ofm_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifm_words <= '0;
      r_wgt_words <= '0;
      r_ofm_words <= '0;
    end else if (r_state == ST_CFG) begin
      r_ifm_words <= w_ifm_words;
      r_wgt_words <= w_wgt_words;
      r_ofm_words <= w_ofm_words;
    end
  end

  // cfg_err is cleared by an accepted start and set by a rejected geometry;
  // cal_start fires on the edge that enters CAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err   <= 1'b0;
      r_cal_start <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && i_start)
        r_cfg_err <= 1'b0;
      else if ((r_state == ST_CFG) && w_cfg_bad && !i_abort)
        r_cfg_err <= 1'b1;
      r_cal_start <= (r_state != ST_CAL) && (w_next == ST_CAL);
    end
  end

  mem_stream_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_ifm_gen (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_go(r_state == ST_LOAD),
    .i_base(r_ifm_base), .i_count(r_ifm_words), .i_ready(mem.ifm_rd_ready),
    .o_valid(mem.ifm_rd_valid), .o_addr(mem.ifm_rd_addr), .o_finished(w_ifm_fin)
  );

  mem_stream_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_wgt_gen (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_go(r_state == ST_LOAD),
    .i_base(r_wgt_base), .i_count(r_wgt_words), .i_ready(mem.wgt_rd_ready),
    .o_valid(mem.wgt_rd_valid), .o_addr(mem.wgt_rd_addr), .o_finished(w_wgt_fin)
  );

  mem_stream_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_ofm_gen (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_go(r_state == ST_STORE),
    .i_base(r_ofm_base), .i_count(r_ofm_words), .i_ready(mem.ofm_wr_ready),
    .o_valid(mem.ofm_wr_valid), .o_addr(mem.ofm_wr_addr), .o_finished(w_ofm_fin)
  );

  assign o_cal_start    = r_cal_start;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = (r_state == ST_DONE);
  assign o_cfg_err      = r_cfg_err;
  assign o_state        = r_state;
  assign o_kernel_w_out = r_kernel_w;
  assign o_ifm_w_out    = r_ifm_w;
  assign o_ifm_c_out    = r_ifm_c;
  assign o_ofm_w_out    = r_ofm_w;
  assign o_ofm_c_out    = r_ofm_c;
  assign o_stride_out   = r_stride;

endmodule
